// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle controller: FSM states, opcodes,
// ALU operation codes and datapath mux selects.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_FAULT    = 4'd11
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/alu_dec.sv
// Combinational ALU operation decode for R-type and I-type arithmetic;
// flags any funct3 outside add/sub/and/or as illegal.
module alu_dec
  import ctrl_pkg::*;
(
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  input  logic       is_rtype_i,
  output logic [1:0] alu_control_o,
  output logic       illegal_o
);

  always_comb begin
    alu_control_o = ALU_ADD;
    illegal_o     = 1'b0;
    case (funct3_i)
      3'b000:  alu_control_o = (is_rtype_i && funct7b5_i) ? ALU_SUB : ALU_ADD;
      3'b111:  alu_control_o = ALU_AND;
      3'b110:  alu_control_o = ALU_OR;
      default: illegal_o     = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle RISC-V style control unit: Moore FSM sequencing fetch, decode,
// memory, ALU, branch and jal steps, with a sticky fault state.
module mc_controller
  import ctrl_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [6:0] op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  input  logic [2:0] alu_flags_i,
  input  logic       mem_ready_i,
  output logic [1:0] alu_control_o,
  output logic [1:0] alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] result_src_o,
  output logic [1:0] imm_src_o,
  output logic       pc_write_o,
  output logic       ir_write_o,
  output logic       reg_write_o,
  output logic       mem_write_o,
  output logic       adr_src_o,
  output logic       retire_o,
  output logic       fault_o
);

  state_e     state_q, state_d;
  logic [1:0] dec_alu_control;
  logic       dec_illegal;
  logic       zero_flag;
  logic       flags_unused;

  assign zero_flag    = alu_flags_i[2];
  assign flags_unused = ^alu_flags_i[1:0];

  alu_dec u_alu_dec (
    .funct3_i      (funct3_i),
    .funct7b5_i    (funct7b5_i),
    .is_rtype_i    (state_q == S_EXECR),
    .alu_control_o (dec_alu_control),
    .illegal_o     (dec_illegal)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_FETCH;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    alu_control_o = ALU_ADD;
    alu_src_a_o   = SRCA_PC;
    alu_src_b_o   = SRCB_RD2;
    result_src_o  = RES_ALUOUT;
    pc_write_o    = 1'b0;
    ir_write_o    = 1'b0;
    reg_write_o   = 1'b0;
    mem_write_o   = 1'b0;
    adr_src_o     = 1'b0;
    retire_o      = 1'b0;
    fault_o       = 1'b0;
    case (state_q)
      S_FETCH: begin
        alu_src_b_o  = SRCB_FOUR;
        result_src_o = RES_ALURES;
        if (mem_ready_i) begin
          ir_write_o = 1'b1;
          pc_write_o = 1'b1;
          state_d    = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_a_o = SRCA_OLDPC;
        alu_src_b_o = SRCB_IMM;
        case (op_i)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          default:           state_d = S_FAULT;
        endcase
      end
      S_MEMADR: begin
        alu_src_a_o = SRCA_RD1;
        alu_src_b_o = SRCB_IMM;
        state_d     = (op_i == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src_o = 1'b1;
        if (mem_ready_i) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src_o = RES_RDATA;
        reg_write_o  = 1'b1;
        retire_o     = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src_o   = 1'b1;
        mem_write_o = 1'b1;
        if (mem_ready_i) begin
          retire_o = 1'b1;
          state_d  = S_FETCH;
        end
      end
      S_EXECR, S_EXECI: begin
        alu_src_a_o   = SRCA_RD1;
        alu_src_b_o   = (state_q == S_EXECR) ? SRCB_RD2 : SRCB_IMM;
        alu_control_o = dec_alu_control;
        state_d       = dec_illegal ? S_FAULT : S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_o = 1'b1;
        retire_o    = 1'b1;
        state_d     = S_FETCH;
      end
      // Only beq/bne are supported; any other compare traps.
      S_BRANCH: begin
        alu_src_a_o   = SRCA_RD1;
        alu_control_o = ALU_SUB;
        case (funct3_i)
          3'b000: begin
            pc_write_o = zero_flag;
            retire_o   = 1'b1;
            state_d    = S_FETCH;
          end
          3'b001: begin
            pc_write_o = ~zero_flag;
            retire_o   = 1'b1;
            state_d    = S_FETCH;
          end
          default: state_d = S_FAULT;
        endcase
      end
      S_JAL: begin
        alu_src_a_o = SRCA_OLDPC;
        alu_src_b_o = SRCB_FOUR;
        pc_write_o  = 1'b1;
        state_d     = S_ALUWB;
      end
      S_FAULT: fault_o = 1'b1;
      default: state_d = S_FETCH;
    endcase
    // Reset masks the decode so nothing leaks out while the state register is forced.
    if (!rst_ni) begin
      alu_control_o = ALU_ADD;
      alu_src_a_o   = SRCA_PC;
      alu_src_b_o   = SRCB_RD2;
      result_src_o  = RES_ALUOUT;
      pc_write_o    = 1'b0;
      ir_write_o    = 1'b0;
      reg_write_o   = 1'b0;
      mem_write_o   = 1'b0;
      adr_src_o     = 1'b0;
      retire_o      = 1'b0;
      fault_o       = 1'b0;
    end
  end

  always_comb begin
    imm_src_o = IMM_I;
    case (op_i)
      OP_STORE:  imm_src_o = IMM_S;
      OP_BRANCH: imm_src_o = IMM_B;
      OP_JAL:    imm_src_o = IMM_J;
      default:   imm_src_o = IMM_I;
    endcase
  end

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: walks each instruction class cycle by
// cycle and compares the packed control word against hand-computed values.
module tb_mc_controller;

  logic       clk;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic [2:0] flags;
  logic       ready;
  logic [1:0] alu_control, src_a, src_b, result_src, imm_src;
  logic       pc_write, ir_write, reg_write, mem_write, adr_src, retire, fault;
  logic [14:0] obs;

  int vectors = 0;
  int miscompares = 0;

  mc_controller dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .op_i          (op),
    .funct3_i      (funct3),
    .funct7b5_i    (funct7b5),
    .alu_flags_i   (flags),
    .mem_ready_i   (ready),
    .alu_control_o (alu_control),
    .alu_src_a_o   (src_a),
    .alu_src_b_o   (src_b),
    .result_src_o  (result_src),
    .imm_src_o     (imm_src),
    .pc_write_o    (pc_write),
    .ir_write_o    (ir_write),
    .reg_write_o   (reg_write),
    .mem_write_o   (mem_write),
    .adr_src_o     (adr_src),
    .retire_o      (retire),
    .fault_o       (fault)
  );

  assign obs = {alu_control, src_a, src_b, result_src,
                pc_write, ir_write, reg_write, mem_write, adr_src, retire, fault};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packs expected fields in the same order as obs.
  function automatic logic [14:0] vec(input logic [1:0] ctl, input logic [1:0] sa,
                                      input logic [1:0] sb, input logic [1:0] rs,
                                      input logic pcw, input logic irw, input logic rw,
                                      input logic mw, input logic as, input logic ret,
                                      input logic flt);
    return {ctl, sa, sb, rs, pcw, irw, rw, mw, as, ret, flt};
  endfunction

  task automatic check_output(input string tag, input logic [14:0] o, input logic [14:0] e);
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic apply_stimulus(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                                input logic [2:0] fl, input logic rdy);
    op = o; funct3 = f3; funct7b5 = f7; flags = fl; ready = rdy;
  endtask

  // Checks the current cycle's control word, then moves to just after the next edge.
  task automatic step(input string tag, input logic [14:0] e);
    #2;
    check_output(tag, obs, e);
    @(posedge clk);
    #1;
  endtask

  logic [14:0] v_f1, v_f0, v_dec, v_madr, v_mrd, v_mwb, v_mw0, v_mw1, v_awb, v_jal, v_flt;

  initial begin
    v_f1   = vec(2'd0, 2'd0, 2'd2, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    v_f0   = vec(2'd0, 2'd0, 2'd2, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    v_dec  = vec(2'd0, 2'd1, 2'd1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    v_madr = vec(2'd0, 2'd2, 2'd1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    v_mrd  = vec(2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    v_mwb  = vec(2'd0, 2'd0, 2'd0, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    v_mw0  = vec(2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    v_mw1  = vec(2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    v_awb  = vec(2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    v_jal  = vec(2'd0, 2'd1, 2'd2, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    v_flt  = vec(2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    rst_n = 1'b0;
    apply_stimulus(7'b0110011, 3'b000, 1'b0, 3'b000, 1'b1);
    #12;
    check_output("reset_strobes", {8'd0, obs[6:0]}, 15'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // add
    step("add_fetch", v_f1);
    check_output("add_imm", {13'd0, imm_src}, 15'd0);
    step("add_decode", v_dec);
    step("add_execr", vec(2'd0, 2'd2, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    step("add_aluwb", v_awb);

    // sub / and / or
    apply_stimulus(7'b0110011, 3'b000, 1'b1, 3'b000, 1'b1);
    step("sub_fetch", v_f1);
    step("sub_decode", v_dec);
    step("sub_execr", vec(2'd1, 2'd2, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    step("sub_aluwb", v_awb);
    apply_stimulus(7'b0110011, 3'b111, 1'b0, 3'b000, 1'b1);
    step("and_fetch", v_f1);
    step("and_decode", v_dec);
    step("and_execr", vec(2'd2, 2'd2, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    step("and_aluwb", v_awb);
    apply_stimulus(7'b0110011, 3'b110, 1'b0, 3'b000, 1'b1);
    step("or_fetch", v_f1);
    step("or_decode", v_dec);
    step("or_execr", vec(2'd3, 2'd2, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    step("or_aluwb", v_awb);

    // addi with bit 30 set must still add
    apply_stimulus(7'b0010011, 3'b000, 1'b1, 3'b000, 1'b1);
    step("addi_fetch", v_f1);
    step("addi_decode", v_dec);
    step("addi_execi", vec(2'd0, 2'd2, 2'd1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    step("addi_aluwb", v_awb);

    // lw with two wait cycles in MEMREAD
    apply_stimulus(7'b0000011, 3'b010, 1'b0, 3'b000, 1'b1);
    step("lw_fetch", v_f1);
    step("lw_decode", v_dec);
    step("lw_memadr", v_madr);
    ready = 1'b0;
    step("lw_memread_w1", v_mrd);
    step("lw_memread_w2", v_mrd);
    ready = 1'b1;
    step("lw_memread_rdy", v_mrd);
    step("lw_memwb", v_mwb);

    // beq taken with a fetch stall, beq not taken, bne both ways
    apply_stimulus(7'b1100011, 3'b000, 1'b0, 3'b100, 1'b0);
    step("beq_fetch_stall", v_f0);
    ready = 1'b1;
    step("beq_fetch", v_f1);
    check_output("beq_imm", {13'd0, imm_src}, 15'd2);
    step("beq_decode", v_dec);
    step("beq_taken", vec(2'd1, 2'd2, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    apply_stimulus(7'b1100011, 3'b000, 1'b0, 3'b000, 1'b1);
    step("beq2_fetch", v_f1);
    step("beq2_decode", v_dec);
    step("beq_not_taken", vec(2'd1, 2'd2, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    apply_stimulus(7'b1100011, 3'b001, 1'b0, 3'b000, 1'b1);
    step("bne_fetch", v_f1);
    step("bne_decode", v_dec);
    step("bne_taken", vec(2'd1, 2'd2, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    apply_stimulus(7'b1100011, 3'b001, 1'b0, 3'b100, 1'b1);
    step("bne2_fetch", v_f1);
    step("bne2_decode", v_dec);
    step("bne_not_taken", vec(2'd1, 2'd2, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));

    // jal
    apply_stimulus(7'b1101111, 3'b000, 1'b0, 3'b000, 1'b1);
    step("jal_fetch", v_f1);
    check_output("jal_imm", {13'd0, imm_src}, 15'd3);
    step("jal_decode", v_dec);
    step("jal_jal", v_jal);
    step("jal_aluwb", v_awb);

    // sw with one wait cycle
    apply_stimulus(7'b0100011, 3'b010, 1'b0, 3'b000, 1'b1);
    step("sw_fetch", v_f1);
    check_output("sw_imm", {13'd0, imm_src}, 15'd1);
    step("sw_decode", v_dec);
    step("sw_memadr", v_madr);
    ready = 1'b0;
    step("sw_memwrite_w", v_mw0);
    ready = 1'b1;
    step("sw_memwrite_rdy", v_mw1);

    // sw abandoned by reset in MEMWRITE
    step("sw2_fetch", v_f1);
    step("sw2_decode", v_dec);
    step("sw2_memadr", v_madr);
    ready = 1'b0;
    #2;
    check_output("sw2_memwrite", obs, v_mw0);
    rst_n = 1'b0;
    #1;
    check_output("sw2_reset_strobes", {8'd0, obs[6:0]}, 15'd0);
    @(posedge clk);
    #1;
    check_output("sw2_reset_hold", {8'd0, obs[6:0]}, 15'd0);
    @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus(7'b1111111, 3'b000, 1'b0, 3'b000, 1'b1);
    step("post_reset_fetch", v_f1);

    // illegal opcode locks into FAULT
    step("ill_decode", v_dec);
    for (int i = 0; i < 10; i++) begin
      ready = i[0];
      step("fault_hold", v_flt);
    end
    rst_n = 1'b0;
    #1;
    check_output("fault_cleared", {8'd0, obs[6:0]}, 15'd0);
    @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus(7'b0110011, 3'b001, 1'b0, 3'b000, 1'b1);
    step("fault_exit_fetch", v_f1);

    // R-type with unsupported funct3 traps after EXECR
    step("rill_decode", v_dec);
    @(posedge clk);
    #1;
    step("rill_fault", v_flt);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
